fifo_byte_serializer: RTL and testbench

Read-side consumer for the tag's 8-bit byte FIFO. On a start request it pops a programmed number of bytes from the FIFO and shifts each byte out MSB-first, one bit per programmable bit period, with a one-cycle strobe at the start of each bit. It sits between the FIFO read port and the backscatter line encoder, and runs in the FIFO read-clock domain. It reports completion and flags mid-frame FIFO underrun.

---
 rtl/fifo_byte_serializer.sv | 122 ++++++++++++
 tb/tb_fifo_byte_serializer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_byte_serializer.sv
// fifo_byte_serializer
// Pops a programmed number of bytes from the tag's byte FIFO and shifts each
// one out MSB-first, one bit per (bit_div+1) clocks, with a strobe on the
// first cycle of every bit. Flags FIFO underrun between bytes of a frame.
module fifo_byte_serializer #(
  parameter int DIV_WIDTH = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 r_clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] byte_count,
  input  logic [DIV_WIDTH-1:0] bit_div,
  input  logic                 fifo_empty,
  input  logic [7:0]           fifo_data,
  output logic                 fifo_read,
  output logic                 tx_bit,
  output logic                 tx_strobe,
  output logic                 busy,
  output logic                 done,
  output logic                 underrun
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);

  logic [2:0]           state;
  logic [CNT_WIDTH-1:0] bytes_left;
  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] div_cnt;
  logic [2:0]           bit_idx;
  logic [7:0]           shift_reg;
  logic                 sent_any;
  logic                 underrun_q;

  wire bit_end = (div_cnt == '0);
  wire last_bit = (bit_idx == 3'd0);

  // Frame control: state sequencing, byte accounting and underrun tracking.
  always_ff @(posedge r_clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      bytes_left <= '0;
      div_q      <= '0;
      sent_any   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            underrun_q <= 1'b0;
            sent_any   <= 1'b0;
            if (byte_count != '0) begin
              bytes_left <= byte_count;
              div_q      <= bit_div;
              state      <= S_FETCH;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_FETCH: begin
          // An empty FIFO before the first byte is just a slow start, not an underrun.
          if (!fifo_empty) state <= S_LOAD;
          else if (sent_any) underrun_q <= 1'b1;
        end
        S_LOAD: state <= S_SHIFT;
        S_SHIFT: begin
          if (bit_end && last_bit) begin
            if (bytes_left == CNT_ONE) begin
              state <= S_DONE;
            end else begin
              bytes_left <= bytes_left - CNT_ONE;
              sent_any   <= 1'b1;
              state      <= S_FETCH;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Bit datapath: byte load, per-bit period counter and MSB-first shift.
  always_ff @(posedge r_clk or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
      bit_idx   <= '0;
      div_cnt   <= '0;
    end else if (state == S_LOAD) begin
      shift_reg <= fifo_data;
      bit_idx   <= 3'd7;
      div_cnt   <= div_q;
    end else if (state == S_SHIFT) begin
      if (!bit_end) begin
        div_cnt <= div_cnt - DIV_ONE;
      end else if (!last_bit) begin
        shift_reg <= {shift_reg[6:0], 1'b0};
        bit_idx   <= bit_idx - 3'd1;
        div_cnt   <= div_q;
      end
    end
  end

  // The counter sits at the latched divisor only on the first cycle of a bit,
  // so that compare doubles as the strobe (every cycle when bit_div is 0).
  assign fifo_read = (state == S_FETCH) && !fifo_empty;
  assign tx_bit    = (state == S_SHIFT) && shift_reg[7];
  assign tx_strobe = (state == S_SHIFT) && (div_cnt == div_q);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  // Visible from the first empty FETCH cycle, sticky thereafter.
  assign underrun  = underrun_q || ((state == S_FETCH) && fifo_empty && sent_any);

endmodule

// File: tb/tb_fifo_byte_serializer.sv
// Directed bench for fifo_byte_serializer: a table of frames checked cycle by
// cycle against a timing model, plus hand sequences for underrun, reset
// mid-frame and start-while-busy.
module tb_fifo_byte_serializer;

  logic       r_clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] byte_count = '0;
  logic [7:0] bit_div = '0;
  logic       fifo_empty;
  logic [7:0] fifo_data = '0;
  logic       fifo_read, tx_bit, tx_strobe, busy, done, underrun;

  int checks = 0;
  int failures = 0;

  fifo_byte_serializer #(.DIV_WIDTH(8), .CNT_WIDTH(8)) dut (
    .r_clk(r_clk), .reset(reset), .start(start), .byte_count(byte_count),
    .bit_div(bit_div), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_read(fifo_read), .tx_bit(tx_bit), .tx_strobe(tx_strobe),
    .busy(busy), .done(done), .underrun(underrun)
  );

  always #5 r_clk = ~r_clk;

  // Bench FIFO: registered output, data valid the cycle after the pop.
  logic [7:0] mem [16];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge r_clk) begin
    if (fifo_read) begin
      fifo_data <= mem[rd_ptr % 16];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  typedef struct {
    int              n;        // byte_count
    int              d;        // bit_div
    logic [3:0][7:0] b;        // b[k] = k-th byte popped
    int              restart;  // cycle to pulse start again (0 = never)
  } frame_t;

  frame_t tbl [6];

  task automatic push(input logic [7:0] v);
    mem[wr_ptr % 16] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic tick();
    @(posedge r_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {2'b00, fifo_read, tx_bit, tx_strobe, busy, done, underrun};
  endfunction

  // Expected {fifo_read,tx_bit,tx_strobe,busy,done,underrun} for cycle c after
  // the start edge, for a stall-free frame.
  function automatic logic [7:0] exp_vec(input frame_t f, input int c);
    int p, blen, dc, k, off, s, i;
    logic rd, bt, sb, by, dn;
    p = f.d + 1;
    blen = 2 + 8 * p;
    dc = f.n * blen + 1;
    rd = 0; bt = 0; sb = 0; by = 0; dn = 0;
    if (c == dc) begin
      by = 1; dn = 1;
    end else if (c < dc) begin
      by = 1;
      k = (c - 1) / blen;
      off = (c - 1) % blen;
      if (off == 0) rd = 1;
      else if (off >= 2) begin
        s = off - 2;
        i = s / p;
        sb = ((s % p) == 0);
        bt = f.b[k][7 - i];
      end
    end
    return {2'b00, rd, bt, sb, by, dn, 1'b0};
  endfunction

  task automatic run_frame(input frame_t f, input string nm);
    int dc;
    dc = f.n * (2 + 8 * (f.d + 1)) + 1;
    for (int k = 0; k < f.n; k++) push(f.b[k]);
    byte_count = 8'(f.n);
    bit_div = 8'(f.d);
    start = 1'b1;
    for (int c = 1; c <= dc + 1; c++) begin
      tick();
      if (c == 1) begin
        byte_count = 8'hEE;  // must already be latched
        bit_div = 8'h77;
      end
      chk($sformatf("%s c%0d", nm, c), outs(), exp_vec(f, c));
      start = (c == f.restart);
    end
    start = 1'b0;
  endtask

  task automatic set_frame(input int idx, input int n, input int d,
                           input logic [31:0] bytes, input int rs);
    tbl[idx].n = n;
    tbl[idx].d = d;
    tbl[idx].b = bytes;
    tbl[idx].restart = rs;
  endtask

  initial begin
    frame_t f;
    set_frame(0, 1, 0, 32'h0000_00A5, 0);  // single byte, fast
    set_frame(1, 2, 2, 32'h0000_3C81, 0);  // two bytes, divided
    set_frame(2, 0, 0, 32'h0000_0000, 0);  // zero-length frame
    set_frame(3, 3, 1, 32'h005A_FF00, 0);  // three bytes, extreme patterns
    set_frame(4, 1, 3, 32'h0000_00C3, 0);  // single byte, period 4
    set_frame(5, 1, 1, 32'h0000_005A, 6);  // start pulsed during SHIFT

    // Reset state
    tick(); tick();
    chk("reset_outs", outs(), 8'h00);
    reset = 1'b0;
    tick();
    chk("idle_after_reset", outs(), 8'h00);

    for (int t = 0; t < 6; t++) begin
      run_frame(tbl[t], $sformatf("frame%0d", t));
      tick();
    end

    // Mid-frame underrun: second byte arrives 5 cycles into the FETCH stall.
    push(8'h12);
    byte_count = 8'd2; bit_div = 8'd0; start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      start = 1'b0;
      if (c == 16) begin
        push(8'hFF);
        #1;
      end
      if (c == 11) chk("ur_first", {6'b0, fifo_read, underrun}, 8'h01);
      if (c >= 12 && c <= 15) chk($sformatf("ur_stall c%0d", c), {6'b0, fifo_read, underrun}, 8'h01);
      if (c == 16) chk("ur_pop", {7'b0, fifo_read}, 8'h01);
      if (c == 17) chk("ur_load", {6'b0, tx_strobe, busy}, 8'h01);
      if (c >= 18 && c <= 25) chk($sformatf("ur_bit c%0d", c), {6'b0, tx_bit, tx_strobe}, 8'h03);
      if (c == 26) chk("ur_done", {6'b0, done, underrun}, 8'h03);
      if (c == 30) chk("ur_sticky", {6'b0, busy, underrun}, 8'h01);
    end
    // Next accepted start clears the flag; checked every cycle as 0.
    f.n = 1; f.d = 0; f.b = 32'h33; f.restart = 0;
    run_frame(f, "ur_clear");
    tick();

    // Reset during the 4th bit of 0xF0.
    push(8'hF0);
    byte_count = 8'd1; bit_div = 8'd1; start = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      start = 1'b0;
    end
    chk("rst_pre", {5'b0, tx_bit, busy, done}, 8'h06);
    reset = 1'b1;
    #1;
    chk("rst_async", outs(), 8'h00);
    tick(); tick();
    reset = 1'b0;
    tick(); tick();
    chk("rst_idle", outs(), 8'h00);
    f.n = 1; f.d = 0; f.b = 32'h0F; f.restart = 0;
    run_frame(f, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
